// File: rtl/param_processor.sv
// Parametrised register-file processor: one instruction per handshake, walked through
// READ/EXEC/WB, with carry/zero flags and an optional hardwired zero register.
module param_processor #(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 32,
    parameter  int ZERO_REG = 0,
    localparam int ADDR_W   = $clog2(NUM_REGS),
    localparam int INSTR_W  = 3 + 3 * ADDR_W + DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [DATA_W-1:0]  rd_data1,
    output logic [DATA_W-1:0]  rd_data2,
    output logic [DATA_W-1:0]  result,
    output logic               carry,
    output logic               zero,
    output logic               done
);

    localparam int SH_W = $clog2(DATA_W);

    localparam logic [2:0] OP_LOADI = 3'b000;
    localparam logic [2:0] OP_READ1 = 3'b001;
    localparam logic [2:0] OP_READ2 = 3'b010;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_ADD   = 3'b101;
    localparam logic [2:0] OP_SUB   = 3'b110;
    localparam logic [2:0] OP_SHL   = 3'b111;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t              state_q, state_d;
    logic [INSTR_W-1:0]  instr_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   rd1_q, rd2_q, result_q;
    logic                carry_q, zero_q, done_q;

    logic [2:0]          op;
    logic [ADDR_W-1:0]   rd_a, rs1_a, rs2_a;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   opnd1, opnd2;
    logic [DATA_W:0]     alu_out;
    logic                accept, writes, wr_en;

    // Returns {carry, result}; carry is only meaningful for AND/ADD/SUB/SHL.
    function automatic logic [DATA_W:0] alu(input logic [2:0]        opc,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic [DATA_W-1:0] im);
        logic [DATA_W:0] r;
        case (opc)
            OP_LOADI: r = {1'b0, im};
            OP_AND:   r = {1'b0, a & b};
            OP_ADD:   r = {1'b0, a} + {1'b0, b};
            OP_SUB:   r = {(a < b), a - b};
            OP_SHL:   r = {1'b0, a} << im[SH_W-1:0];
            default:  r = {1'b0, a};
        endcase
        return r;
    endfunction

    assign op    = instr_q[INSTR_W-1 -: 3];
    assign rd_a  = instr_q[DATA_W+3*ADDR_W-1 -: ADDR_W];
    assign rs1_a = instr_q[DATA_W+2*ADDR_W-1 -: ADDR_W];
    assign rs2_a = instr_q[DATA_W+ADDR_W-1 -: ADDR_W];
    assign imm   = instr_q[DATA_W-1:0];

    assign instr_ready = (state_q == IDLE) & ~reset;
    assign accept      = instr_valid & instr_ready;

    assign opnd1   = (ZERO_REG != 0 && rs1_a == '0) ? '0 : regs_q[rs1_a];
    assign opnd2   = (ZERO_REG != 0 && rs2_a == '0) ? '0 : regs_q[rs2_a];
    assign alu_out = alu(op, rd1_q, rd2_q, imm);

    assign writes = (op != OP_READ1) && (op != OP_READ2);
    assign wr_en  = (state_q == WB) && writes && !(ZERO_REG != 0 && rd_a == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = READ;
            READ:    state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q  <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state_q == WB);
            if (accept) begin
                instr_q <= instr;
            end
            if (state_q == READ) begin
                rd1_q <= opnd1;
                rd2_q <= opnd2;
            end
            if (state_q == EXEC) begin
                result_q <= alu_out[DATA_W-1:0];
                // Only the computing opcodes (MSB set) touch the flags.
                if (op[2]) begin
                    carry_q <= alu_out[DATA_W];
                    zero_q  <= (alu_out[DATA_W-1:0] == '0);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[rd_a] <= result_q;
        end
    end

    assign rd_data1 = rd1_q;
    assign rd_data2 = rd2_q;
    assign result   = result_q;
    assign carry    = carry_q;
    assign zero     = zero_q;
    assign done     = done_q;

endmodule

// File: tb/tb_param_processor.sv
// Bench for param_processor: a 16-bit/32-register instance and an 8-bit/8-register
// zero-register instance, driven by directed and random instructions against a model.
module tb_param_processor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, a_valid, a_ready, a_c, a_z, a_done;
    logic [33:0] a_instr;
    logic [15:0] a_rd1, a_rd2, a_res;

    logic        rst_b, b_valid, b_ready, b_c, b_z, b_done;
    logic [19:0] b_instr;
    logic [7:0]  b_rd1, b_rd2, b_res;

    param_processor #(.DATA_W(16), .NUM_REGS(32), .ZERO_REG(0)) dut_a (
        .clk(clk), .reset(rst_a), .instr_valid(a_valid), .instr(a_instr),
        .instr_ready(a_ready), .rd_data1(a_rd1), .rd_data2(a_rd2), .result(a_res),
        .carry(a_c), .zero(a_z), .done(a_done)
    );

    param_processor #(.DATA_W(8), .NUM_REGS(8), .ZERO_REG(1)) dut_b (
        .clk(clk), .reset(rst_b), .instr_valid(b_valid), .instr(b_instr),
        .instr_ready(b_ready), .rd_data1(b_rd1), .rd_data2(b_rd2), .result(b_res),
        .carry(b_c), .zero(b_z), .done(b_done)
    );

    int checks = 0;
    int failures = 0;

    // Architectural state of each instance: register values and flags.
    longint mreg [2][32];
    bit     mc [2];
    bit     mz [2];

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear(input bit sel);
        for (int i = 0; i < 32; i++) mreg[sel][i] = 0;
        mc[sel] = 0;
        mz[sel] = 0;
    endtask

    // Instruction semantics with plain integer arithmetic on width w.
    function automatic void model_exec(input int w, input int op, input longint a,
                                       input longint b, input longint imm,
                                       output longint r, output bit c);
        longint modulus = longint'(1) << w;
        longint sh;
        longint full;
        c = 0;
        case (op)
            0: r = imm % modulus;
            4: r = a & b;
            5: begin full = a + b; r = full % modulus; c = (full >= modulus); end
            6: begin r = (a - b + modulus) % modulus; c = (a < b); end
            7: begin
                sh   = imm % (longint'(1) << $clog2(w));
                full = a * (longint'(1) << sh);
                r    = full % modulus;
                c    = ((full / modulus) % 2) == 1;
            end
            default: r = a;
        endcase
    endfunction

    // Drives one instruction from a falling edge and checks every stage of it.
    task automatic issue(input bit sel, input int op, input int rd, input int rs1,
                         input int rs2, input longint imm, input bit hold = 0);
        string  p = sel ? "B." : "A.";
        int     w = sel ? 8 : 16;
        longint a, b, r;
        bit     c;
        a = (sel && rs1 == 0) ? 0 : mreg[sel][rs1];
        b = (sel && rs2 == 0) ? 0 : mreg[sel][rs2];
        model_exec(w, op, a, b, imm, r, c);
        if (sel) begin
            b_instr = {3'(op), 3'(rd), 3'(rs1), 3'(rs2), 8'(imm)};
            b_valid = 1'b1;
        end else begin
            a_instr = {3'(op), 5'(rd), 5'(rs1), 5'(rs2), 16'(imm)};
            a_valid = 1'b1;
        end
        chk({p, "ready_idle"}, sel ? b_ready : a_ready, 1);
        @(posedge clk); @(negedge clk);
        chk({p, "done_after_accept"}, sel ? b_done : a_done, 0);
        if (!hold) begin
            a_valid = 1'b0;
            b_valid = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        chk({p, "rd_data1"}, sel ? b_rd1 : a_rd1, a);
        chk({p, "rd_data2"}, sel ? b_rd2 : a_rd2, b);
        @(posedge clk); @(negedge clk);
        if (op >= 4) begin
            mc[sel] = c;
            mz[sel] = (r == 0);
        end
        chk({p, "result"}, sel ? b_res : a_res, r);
        chk({p, "carry"}, sel ? b_c : a_c, mc[sel]);
        chk({p, "zero"}, sel ? b_z : a_z, mz[sel]);
        chk({p, "ready_busy"}, sel ? b_ready : a_ready, 0);
        @(posedge clk); @(negedge clk);
        if ((op == 0 || op >= 3) && !(sel && rd == 0)) mreg[sel][rd] = r;
        chk({p, "done"}, sel ? b_done : a_done, 1);
        chk({p, "ready_done"}, sel ? b_ready : a_ready, 1);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        a_instr = '0; b_instr = '0;
        model_clear(0);
        model_clear(1);
        @(negedge clk);
        chk("A.ready_in_reset", a_ready, 0);
        chk("B.ready_in_reset", b_ready, 0);
        chk("A.reset_result", a_res, 0);
        chk("A.reset_rd1", a_rd1, 0);
        chk("A.reset_flags", {a_c, a_z, a_done}, 0);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        chk("A.ready_after_release", a_ready, 1);
        chk("B.ready_after_release", b_ready, 1);

        // Directed sequence on the 16-bit instance; each issue starts in the prior done cycle.
        issue(0, 0, 3, 0, 0, 'h1234);
        issue(0, 1, 0, 3, 0, 0);
        issue(0, 0, 1, 0, 0, 'hFFFF);
        issue(0, 0, 2, 0, 0, 'h0001);
        issue(0, 5, 4, 1, 2, 0);
        issue(0, 2, 0, 4, 1, 0);
        issue(0, 0, 1, 0, 0, 3);
        issue(0, 0, 2, 0, 0, 5);
        issue(0, 6, 6, 1, 2, 0);
        issue(0, 6, 7, 1, 1, 0);
        issue(0, 0, 1, 0, 0, 'h8001);
        issue(0, 7, 5, 1, 0, 1);
        issue(0, 7, 5, 1, 0, 0);
        issue(0, 4, 8, 1, 5, 0);
        issue(0, 3, 9, 6, 0, 0);
        issue(0, 5, 6, 6, 6, 0, 1);
        issue(0, 2, 0, 9, 6, 0);

        for (int i = 0; i < 40; i++) begin
            issue(0, $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), longint'($urandom_range(0, 'hFFFF)), 1'($urandom_range(0, 1)));
        end

        // Zero-register instance.
        issue(1, 0, 0, 0, 0, 'h5A);
        issue(1, 1, 0, 0, 0, 0);
        issue(1, 0, 7, 0, 0, 'h33);
        issue(1, 3, 7, 0, 0, 0);
        issue(1, 1, 0, 7, 0, 0);
        issue(1, 0, 1, 0, 0, 'hF0);
        issue(1, 0, 2, 0, 0, 'h20);
        issue(1, 5, 3, 1, 2, 0);
        for (int i = 0; i < 25; i++) begin
            issue(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), longint'($urandom_range(0, 'hFF)));
        end

        // Reset asserted while an ADD rd=2 sits in EXEC.
        issue(0, 0, 1, 0, 0, 'h0077);
        a_instr = {3'b101, 5'd2, 5'd1, 5'd1, 16'd0};
        a_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        a_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("A.rd1_before_abort", a_rd1, 'h77);
        rst_a = 1'b1;
        #1;
        chk("A.ready_abort", a_ready, 0);
        chk("A.rd1_abort", a_rd1, 0);
        chk("A.result_abort", a_res, 0);
        @(negedge clk);
        rst_a = 1'b0;
        model_clear(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("A.no_done_after_abort", a_done, 0);
            chk("A.ready_after_abort", a_ready, 1);
        end
        issue(0, 2, 0, 2, 1, 0);
        issue(0, 5, 10, 2, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0x0 expected=0x1");
        $fatal(1, "timeout");
    end

endmodule
